// File: rtl/dds_freq_scheduler_if.sv
// Calculator start/ready handshake plus the tuning-word bus towards the DDS slaves.
interface dds_freq_scheduler_if #(
    parameter int N_CH = 4
);
    logic               calc_start;
    logic [31:0]        calc_freq;
    logic               calc_ready;
    logic [N_CH*16-1:0] dds_freq;
    logic               freq_valid;

    modport master (
        output calc_start, dds_freq, freq_valid,
        input  calc_freq, calc_ready
    );

    modport slave (
        input  calc_start, dds_freq, freq_valid,
        output calc_freq, calc_ready
    );
endinterface

// File: rtl/dds_freq_scheduler.sv
// Schedules B-field-to-frequency calculations and distributes the offset result
// to the DDS channel tuning words, immediately or aligned to dds_sync.
module dds_freq_scheduler #(
    parameter int N_CH     = 4,
    parameter int TIMEOUT  = 64,
    parameter int PERIOD_W = 16
) (
    input  logic                 int_dds_clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PERIOD_W-1:0]  period,
    input  logic                 force_update,
    input  logic                 sync_mode,
    input  logic                 dds_sync,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic [N_CH*32-1:0]   ch_offset,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 timeout_err,
    dds_freq_scheduler_if.master calc_if
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_PEND  = 3'd3;
    localparam logic [2:0] ST_APPLY = 3'd4;

    logic [2:0]          state, state_nxt;
    logic [PERIOD_W-1:0] period_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic                force_pend;
    logic [31:0]         freq_lat;
    logic [2:0]          sync_sr;
    logic                sync_rise;
    logic [31:0]         apply_src;
    logic [15:0]         ch_word;
    logic [N_CH*16-1:0]  dds_freq_r, dds_freq_nxt;
    logic                calc_start_r, freq_valid_r, timeout_err_r;
    logic                tmo_expire;

    assign sync_rise  = sync_sr[1] & ~sync_sr[2];
    assign tmo_expire = (state == ST_WAIT) && !calc_if.calc_ready && (tmo_cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if ((enable && period_cnt == '0) || force_pend) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (calc_if.calc_ready) state_nxt = sync_mode ? ST_PEND : ST_APPLY;
                else if (tmo_cnt == '0) state_nxt = ST_IDLE;
            end
            ST_PEND:  if (sync_rise) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Words are registered on the edge entering APPLY so they appear together with
    // freq_valid; coming straight from WAIT the latch is not yet loaded, so bypass it.
    always_comb begin
        apply_src    = (state == ST_WAIT) ? calc_if.calc_freq : freq_lat;
        dds_freq_nxt = dds_freq_r;
        ch_word      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            ch_word = 16'((apply_src + ch_offset[32*k +: 32]) >> 16);
            if (ch_mask[k]) dds_freq_nxt[16*k +: 16] = ch_word;
        end
    end

    always_ff @(posedge int_dds_clk_in or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            period_cnt    <= '0;
            tmo_cnt       <= '0;
            force_pend    <= 1'b0;
            freq_lat      <= '0;
            sync_sr       <= '0;
            dds_freq_r    <= '0;
            calc_start_r  <= 1'b0;
            freq_valid_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state        <= state_nxt;
            sync_sr      <= {sync_sr[1:0], dds_sync};
            calc_start_r <= (state_nxt == ST_START);
            freq_valid_r <= (state_nxt == ST_APPLY);

            if (state_nxt == ST_START) period_cnt <= period;
            else if (enable && period_cnt != '0) period_cnt <= period_cnt - 1'b1;

            if (state_nxt == ST_START) force_pend <= 1'b0;
            else if (force_update) force_pend <= 1'b1;

            if (state_nxt == ST_START) tmo_cnt <= TW'(TIMEOUT - 1);
            else if (state == ST_WAIT && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

            if (state == ST_WAIT && calc_if.calc_ready) freq_lat <= calc_if.calc_freq;

            if (state_nxt == ST_APPLY && state != ST_APPLY) dds_freq_r <= dds_freq_nxt;

            if (tmo_expire) timeout_err_r <= 1'b1;
            else if (err_clr) timeout_err_r <= 1'b0;
        end
    end

    assign busy               = (state != ST_IDLE);
    assign timeout_err        = timeout_err_r;
    assign calc_if.calc_start = calc_start_r;
    assign calc_if.dds_freq   = dds_freq_r;
    assign calc_if.freq_valid = freq_valid_r;
endmodule

// File: tb/tb_dds_freq_scheduler.sv
// Directed and randomized checks of dds_freq_scheduler against a behavioural model.
module tb_dds_freq_scheduler;
    localparam int N_CH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [15:0]         period;
    logic                force_update;
    logic                sync_mode;
    logic                dds_sync;
    logic [N_CH-1:0]     ch_mask;
    logic [N_CH*32-1:0]  ch_offset;
    logic                err_clr;
    logic                busy;
    logic                timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_w [N_CH];

    dds_freq_scheduler_if #(.N_CH(N_CH)) cif ();

    dds_freq_scheduler #(.N_CH(N_CH), .TIMEOUT(64), .PERIOD_W(16)) dut (
        .int_dds_clk_in (clk),
        .reset          (reset),
        .enable         (enable),
        .period         (period),
        .force_update   (force_update),
        .sync_mode      (sync_mode),
        .dds_sync       (dds_sync),
        .ch_mask        (ch_mask),
        .ch_offset      (ch_offset),
        .err_clr        (err_clr),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .calc_if        (cif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: signed offset added with wide arithmetic, wrapped to 32 bits, top half kept.
    task automatic model_apply(input logic [31:0] f);
        longint s;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_mask[k]) begin
                s = (longint'({32'd0, f}) + longint'($signed(ch_offset[32*k +: 32]))) & 64'h0000_0000_FFFF_FFFF;
                exp_w[k] = 16'(s / 65536);
            end
        end
    endtask

    function automatic logic [63:0] exp_bus();
        logic [63:0] b;
        for (int k = 0; k < N_CH; k++) b[16*k +: 16] = exp_w[k];
        return b;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N_CH; k++) exp_w[k] = 16'h0;
    endtask

    task automatic wait_start(output int t);
        int n;
        n = 0;
        while (cif.calc_start !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk("start_seen", {63'd0, cif.calc_start}, 64'd1);
        t = cyc;
    endtask

    task automatic do_force();
        force_update = 1'b1;
        step(1);
        force_update = 1'b0;
    endtask

    // Bench acts as the calculator: ready after lat cycles, immediate-apply mode.
    task automatic run_txn(input logic [31:0] f, input int lat, output int t0);
        wait_start(t0);
        step(1);
        chk("start_one_cycle", {63'd0, cif.calc_start}, 64'd0);
        for (int i = 1; i < lat; i++) step(1);
        chk("no_early_valid", {63'd0, cif.freq_valid}, 64'd0);
        cif.calc_ready = 1'b1;
        cif.calc_freq  = f;
        step(1);
        cif.calc_ready = 1'b0;
        model_apply(f);
        chk("valid_after_ready", {63'd0, cif.freq_valid}, 64'd1);
        chk("dds_word", cif.dds_freq, exp_bus());
        step(1);
        chk("valid_single", {63'd0, cif.freq_valid}, 64'd0);
        chk("idle_after_apply", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int t0, t1, t2, cnt, cnt2, p, lat;
        logic [31:0] f;

        reset = 1'b1; enable = 1'b0; period = 16'd9; force_update = 1'b0;
        sync_mode = 1'b0; dds_sync = 1'b0; ch_mask = 4'hF; ch_offset = '0; err_clr = 1'b0;
        cif.calc_ready = 1'b0; cif.calc_freq = '0;
        model_clear();
        step(2);
        chk("rst_calc_start", {63'd0, cif.calc_start}, 64'd0);
        chk("rst_freq_valid", {63'd0, cif.freq_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
        chk("rst_dds_freq", cif.dds_freq, 64'd0);
        reset = 1'b0;

        // Periodic update, period 9 -> starts 10 clocks apart
        enable = 1'b1;
        run_txn(32'h1234_5678, 3, t0);
        chk("periodic_word", cif.dds_freq, 64'h1234_1234_1234_1234);
        run_txn(32'h1234_5678, 3, t1);
        chk("period_spacing_1", 64'(t1 - t0), 64'd10);
        run_txn(32'h1234_5678, 3, t2);
        chk("period_spacing_2", 64'(t2 - t1), 64'd10);
        enable = 1'b0;

        // Offset and mask
        ch_offset = {32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000};
        ch_mask   = 4'b0111;
        do_force();
        run_txn(32'h8000_0000, 2, t0);
        chk("offset_mask_word", cif.dds_freq, 64'h1234_7FFF_7FFF_8001);
        ch_offset = '0;
        ch_mask   = 4'hF;

        // Timeout: 64 clocks in WAIT
        do_force();
        wait_start(t0);
        cnt = 0;
        repeat (64) begin
            step(1);
            if (cif.freq_valid) cnt++;
        end
        chk("tmo_not_early", {63'd0, timeout_err}, 64'd0);
        chk("tmo_busy_in_wait", {63'd0, busy}, 64'd1);
        step(1);
        chk("tmo_flag_set", {63'd0, timeout_err}, 64'd1);
        chk("tmo_back_idle", {63'd0, busy}, 64'd0);
        chk("tmo_no_valid", 64'(cnt) + {63'd0, cif.freq_valid}, 64'd0);
        chk("tmo_dds_held", cif.dds_freq, exp_bus());
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("tmo_err_clr", {63'd0, timeout_err}, 64'd0);

        // err_clr held through expiry: set wins
        err_clr = 1'b1;
        do_force();
        wait_start(t0);
        step(65);
        chk("tmo_set_wins", {63'd0, timeout_err}, 64'd1);
        err_clr = 1'b0;
        step(1);
        chk("tmo_sticky", {63'd0, timeout_err}, 64'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("tmo_err_clr_2", {63'd0, timeout_err}, 64'd0);

        // Ready in the final timeout cycle wins
        do_force();
        run_txn(32'hCAFE_9876, 64, t0);
        chk("tmo_ready_wins", {63'd0, timeout_err}, 64'd0);

        // Sync alignment; sync_mode dropped while pending must not matter
        sync_mode = 1'b1;
        do_force();
        wait_start(t0);
        step(3);
        cif.calc_ready = 1'b1;
        cif.calc_freq  = 32'h5A5A_0001;
        step(1);
        cif.calc_ready = 1'b0;
        sync_mode = 1'b0;
        cnt = 0;
        repeat (19) begin
            if (cif.freq_valid || cif.dds_freq !== exp_bus()) cnt++;
            step(1);
        end
        chk("sync_wait_quiet", 64'(cnt), 64'd0);
        chk("sync_busy_pend", {63'd0, busy}, 64'd1);
        dds_sync = 1'b1;
        step(2);
        chk("sync_no_early_valid", {63'd0, cif.freq_valid}, 64'd0);
        chk("sync_no_early_word", cif.dds_freq, exp_bus());
        step(1);
        model_apply(32'h5A5A_0001);
        chk("sync_valid", {63'd0, cif.freq_valid}, 64'd1);
        chk("sync_word", cif.dds_freq, exp_bus());
        step(1);
        chk("sync_valid_single", {63'd0, cif.freq_valid}, 64'd0);
        chk("sync_idle", {63'd0, busy}, 64'd0);
        dds_sync = 1'b0;

        // Force while busy: second start right after return to IDLE
        do_force();
        wait_start(t0);
        step(1);
        force_update = 1'b1;
        step(1);
        force_update = 1'b0;
        step(1);
        cif.calc_ready = 1'b1;
        cif.calc_freq  = 32'h0F0F_0000;
        step(1);
        cif.calc_ready = 1'b0;
        model_apply(32'h0F0F_0000);
        chk("fwb_first_valid", {63'd0, cif.freq_valid}, 64'd1);
        chk("fwb_first_word", cif.dds_freq, exp_bus());
        step(1);
        chk("fwb_idle", {63'd0, busy}, 64'd0);
        run_txn(32'hF0F0_0000, 2, t1);
        chk("fwb_second_start", 64'(t1 - t0), 64'd6);
        cnt = 0;
        repeat (15) begin
            step(1);
            if (cif.calc_start) cnt++;
        end
        chk("fwb_no_third_start", 64'(cnt), 64'd0);

        // Reset while in PEND, with a force request pending
        sync_mode = 1'b1;
        do_force();
        wait_start(t0);
        step(1);
        cif.calc_ready = 1'b1;
        cif.calc_freq  = 32'h7777_0000;
        force_update   = 1'b1;
        step(1);
        cif.calc_ready = 1'b0;
        force_update   = 1'b0;
        step(2);
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_calc_start", {63'd0, cif.calc_start}, 64'd0);
        chk("mid_rst_freq_valid", {63'd0, cif.freq_valid}, 64'd0);
        chk("mid_rst_timeout_err", {63'd0, timeout_err}, 64'd0);
        chk("mid_rst_dds", cif.dds_freq, 64'd0);
        step(1);
        reset = 1'b0;
        sync_mode = 1'b0;
        dds_sync = 1'b1;
        cnt = 0;
        cnt2 = 0;
        repeat (12) begin
            step(1);
            if (cif.calc_start) cnt++;
            if (cif.freq_valid) cnt2++;
        end
        chk("post_rst_no_start", 64'(cnt), 64'd0);
        chk("post_rst_no_valid", 64'(cnt2), 64'd0);
        chk("post_rst_dds", cif.dds_freq, 64'd0);
        dds_sync = 1'b0;

        // Randomized forced updates
        for (int i = 0; i < 10; i++) begin
            ch_mask   = 4'($urandom);
            ch_offset = {$urandom, $urandom, $urandom, $urandom};
            f   = $urandom;
            lat = int'($urandom_range(1, 12));
            do_force();
            run_txn(f, lat, t0);
        end

        // Randomized period
        p = int'($urandom_range(8, 20));
        period = 16'(p);
        ch_mask = 4'hF;
        enable = 1'b1;
        run_txn($urandom, int'($urandom_range(1, p - 3)), t0);
        for (int i = 0; i < 3; i++) begin
            run_txn($urandom, int'($urandom_range(1, p - 3)), t1);
            chk("rand_period_spacing", 64'(t1 - t0), 64'(p + 1));
            t0 = t1;
        end
        enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dds_freq_scheduler.md
Name: dds_freq_scheduler

Overview:
- Sequences the B-field-to-frequency calculator and distributes its result to the four DDS slave channels.
- Periodically, or on demand, pulses the calculator start, waits for ready with a timeout, then adds a per-channel offset.
- Updates the enabled channels' 16-bit tuning words in the same cycle, either immediately or aligned to the external dds_sync edge.
- Sits between the calculator and the dds_slave freq inputs in llrf_afe; the calculator runs on int_dds_clk_in.

Parameters:
- N_CH, 4, number of DDS channels driven.
- TIMEOUT, 64, clocks allowed between calc_start and calc_ready.
- PERIOD_W, 16, width of the update-period register.

Ports:
- int_dds_clk_in  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  periodic scheduling enable.
- period  in  PERIOD_W  clocks between successive starts.
- force_update  in  1  one-cycle request for an immediate calculation.
- sync_mode  in  1  0 = apply on ready; 1 = apply on dds_sync rising edge.
- dds_sync  in  1  asynchronous external sync.
- ch_mask  in  N_CH  1 = channel follows updates.
- ch_offset  in  N_CH*32  per-channel signed offset; channel k uses bits [32k+31:32k].
- calc_freq  in  32  calculator result.
- calc_ready  in  1  calculator result valid.
- calc_start  out  1  one-cycle start pulse to calculator.
- dds_freq  out  N_CH*16  tuning words; channel k uses bits [16k+15:16k].
- freq_valid  out  1  one-cycle pulse in the cycle dds_freq changes.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky timeout flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset values: state IDLE; calc_start, freq_valid, busy, timeout_err = 0; dds_freq all 0; period counter 0; force pending 0; latched freq 0; sync synchronizer 0.
- force_update sets a pending flag. The flag is cleared on entry to START. A force while busy is held and served on return to IDLE.
- Period counter:
  - Decrements each cycle while enable=1 and counter != 0, in any state.
  - Saturates at 0.
  - Reloaded with period on the edge that enters START.
  - With enable=0 it holds its value.
- IDLE: if (enable && counter==0) or force pending, go to START next cycle. Otherwise stay.
- START: calc_start=1 for exactly this cycle. Load the timeout counter with TIMEOUT-1. Go to WAIT. calc_ready is ignored in START.
- WAIT:
  - If calc_ready: latch calc_freq, then go to PEND if sync_mode=1, else APPLY.
  - Else if the timeout counter is 0: set timeout_err, go to IDLE, dds_freq unchanged.
  - Else decrement the timeout counter.
  - calc_ready in the expiry cycle wins over the timeout.
- PEND:
  - dds_sync passes through a 2-FF synchronizer followed by a rising-edge detect.
  - On a detected edge, go to APPLY.
  - An edge already detected in the WAIT->PEND cycle is not used.
  - No timeout in PEND.
- APPLY:
  - For each k with ch_mask[k]=1: dds_freq[k] <= (latched + ch_offset[k]) mod 2^32, bits [31:16].
  - Channels with mask 0 hold their value.
  - freq_valid=1 this cycle, even when the mask is 0.
  - Go to IDLE.
- sync_mode and ch_mask/ch_offset are sampled in WAIT/APPLY respectively. Changing them mid-cycle affects only later samples.
- enable low does not abort a cycle already in flight.
- Latency, sync_mode=0: calc_start in cycle t, calc_ready in cycle t+n (n>=1), dds_freq and freq_valid in cycle t+n+1.
- Start spacing: with a calculation shorter than period, calc_start pulses are period+1 clocks apart. Otherwise the next start follows the first IDLE cycle.
- err_clr clears timeout_err; a simultaneous set wins.
- Reset asserted mid-operation returns everything to reset values immediately. A pending force request is lost.

Test Plan:
- Periodic update:
  - Stimulus: reset, enable=1, period=9, sync_mode=0, mask=4'hF, offsets 0; model returns calc_freq=32'h1234_5678 three cycles after start.
  - Response: calc_start pulses every 10 clocks; all dds_freq=16'h1234; freq_valid one cycle after calc_ready.
- Offset and mask:
  - Stimulus: ch_offset = {+32'h0001_0000, -32'h0001_0000, 32'hFFFF_0000, 0}, mask=4'b0111, calc_freq=32'h8000_0000.
  - Response: ch0=16'h8001, ch1=16'h7FFF, ch2=16'h7FFF, ch3 holds its previous value.
- Timeout:
  - Stimulus: calc_ready never asserts.
  - Response: after 64 clocks in WAIT, timeout_err=1, dds_freq unchanged, no freq_valid.
  - Stimulus: err_clr.
  - Response: timeout_err=0.
  - Stimulus: ready in the final timeout cycle.
  - Response: update occurs and timeout_err stays 0.
- Sync alignment:
  - Stimulus: sync_mode=1, calc_ready arrives, dds_sync rises 20 clocks later.
  - Response: dds_freq changes 3 clocks after the dds_sync rise, with a single freq_valid; no update before the edge.
- Force while busy:
  - Stimulus: enable=0, force_update at t, a second force during WAIT.
  - Response: exactly two calc_start pulses, the second in the cycle after the first cycle's return to IDLE.
- Reset mid-operation:
  - Stimulus: assert reset while in PEND.
  - Response: all outputs 0 asynchronously; after release, no update occurs until a new start.
